// File: rtl/mt_dp_sched_pkg.sv
// Shared types and sizing helpers for the multi-thread dispatch scheduler.
// Imported by the scheduler top and the per-thread recovery FSM.
package mt_dp_sched_pkg;

   localparam int DEF_THREAD_NUM = 2;
   localparam int DEF_DP_NUM     = 2;
   localparam int DEF_RCV_CYC    = 2;

   typedef enum logic {
      RUN,
      RECOVER
   } thr_state_e;

   function automatic int cnt_width(input int dp_num);
      return $clog2(dp_num + 1);
   endfunction

   function automatic int thread_width(input int thread_num);
      return (thread_num > 1) ? $clog2(thread_num) : 1;
   endfunction

endpackage

// File: rtl/mt_dp_sched_rcv.sv
// Per-thread rollback recovery FSM: blocks the thread for RCV_CYC
// cycles after each rollback strobe, restarting on a repeat rollback.
module mt_thread_rcv
   import mt_dp_sched_pkg::*;
#(
   parameter int RCV_CYC = DEF_RCV_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic rollback,
   output logic busy
);

   localparam int RCV_W = (RCV_CYC > 1) ? $clog2(RCV_CYC) : 1;
   localparam logic [RCV_W-1:0] CNT_INIT = RCV_W'(RCV_CYC - 1);

   thr_state_e       state_q, state_d;
   logic [RCV_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (rollback) begin
         state_d = RECOVER;
         cnt_d   = CNT_INIT;
      end else if (state_q == RECOVER) begin
         if (cnt_q == '0) begin
            state_d = RUN;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   assign busy = (state_q == RECOVER);

endmodule

// File: rtl/mt_dp_sched.sv
// Dispatch scheduler: round-robin picks one thread per cycle, sizes its
// grant by ROB/RS/free-list space, and packs it onto the map table ports.
module mt_dp_sched
   import mt_dp_sched_pkg::*;
#(
   parameter int THREAD_NUM = DEF_THREAD_NUM,
   parameter int DP_NUM     = DEF_DP_NUM,
   parameter int RCV_CYC    = DEF_RCV_CYC,
   localparam int CNT_W     = cnt_width(DP_NUM),
   localparam int THREAD_W  = thread_width(THREAD_NUM)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [THREAD_NUM*CNT_W-1:0]    dp_req_i,
   input  logic [THREAD_NUM*CNT_W-1:0]    rob_avail_i,
   input  logic [CNT_W-1:0]               rs_avail_i,
   input  logic [CNT_W-1:0]               fl_avail_i,
   input  logic [THREAD_NUM-1:0]          rollback_i,
   output logic [THREAD_NUM*CNT_W-1:0]    dp_gnt_o,
   output logic [DP_NUM-1:0]              port_valid_o,
   output logic [DP_NUM*THREAD_W-1:0]     port_thread_o,
   output logic [THREAD_NUM-1:0]          mt_rollback_o,
   output logic [THREAD_NUM-1:0]          busy_o
);

   localparam logic [CNT_W-1:0] DP_MAX = CNT_W'(DP_NUM);

   logic [THREAD_W-1:0]   rr_q, rr_d;
   logic [THREAD_NUM-1:0] rcv_busy;
   logic [THREAD_NUM-1:0] elig;
   logic                  found;
   logic                  grant;
   logic [THREAD_W-1:0]   win;
   logic [CNT_W-1:0]      n;
   logic [CNT_W-1:0]      req_w;
   logic [CNT_W-1:0]      rob_w;

   for (genvar t = 0; t < THREAD_NUM; t++) begin : g_thr
      mt_thread_rcv #(
         .RCV_CYC (RCV_CYC)
      ) u_rcv (
         .clk      (clk_i),
         .rst      (rst_i),
         .rollback (rollback_i[t]),
         .busy     (rcv_busy[t])
      );

      assign elig[t] = !rcv_busy[t]
                    && !rollback_i[t]
                    && (dp_req_i[t*CNT_W +: CNT_W] != '0)
                    && (rob_avail_i[t*CNT_W +: CNT_W] != '0)
                    && (rs_avail_i != '0)
                    && (fl_avail_i != '0);
   end

   always_comb begin
      int idx;
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < THREAD_NUM; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= THREAD_NUM) idx = idx - THREAD_NUM;
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = THREAD_W'(idx);
         end
      end
   end

   assign grant = found && !rst_i;
   assign req_w = dp_req_i[int'(win)*CNT_W +: CNT_W];
   assign rob_w = rob_avail_i[int'(win)*CNT_W +: CNT_W];

   always_comb begin
      n = DP_MAX;
      if (req_w < n)      n = req_w;
      if (rob_w < n)      n = rob_w;
      if (rs_avail_i < n) n = rs_avail_i;
      if (fl_avail_i < n) n = fl_avail_i;
      if (!grant)         n = '0;
   end

   always_comb begin
      dp_gnt_o = '0;
      for (int t = 0; t < THREAD_NUM; t++) begin
         if (grant && (win == THREAD_W'(t)))
            dp_gnt_o[t*CNT_W +: CNT_W] = n;
      end
   end

   always_comb begin
      port_valid_o  = '0;
      port_thread_o = '0;
      for (int k = 0; k < DP_NUM; k++) begin
         if (k < int'(n)) begin
            port_valid_o[k]                     = 1'b1;
            port_thread_o[k*THREAD_W +: THREAD_W] = win;
         end
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (grant) begin
         if (int'(win) == THREAD_NUM - 1) rr_d = '0;
         else                              rr_d = win + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rr_q <= '0;
      else       rr_q <= rr_d;
   end

   assign mt_rollback_o = rollback_i & {THREAD_NUM{!rst_i}};
   assign busy_o        = rcv_busy & {THREAD_NUM{!rst_i}};

endmodule

// File: doc/mt_dp_sched.md
Name: mt_dp_sched

Overview:
- Dispatch-side scheduler that shares the map table's DP_NUM read/write ports among THREAD_NUM hardware threads.
- Each cycle it picks one thread with round-robin fairness and computes how many instructions that thread may dispatch, limited by per-thread ROB space, RS space and free-list space.
- It drives per-port valid and thread-index signals, which become the map table's read_en/write_en and thread idx fields.
- It sequences per-thread rollback: it pulses the map table's rollback, then blocks that thread for RCV_CYC cycles while the AMT restore settles.

Parameters:
- THREAD_NUM, 2, number of hardware threads (>=1).
- DP_NUM, 2, map table dispatch ports, i.e. maximum instructions dispatched per cycle.
- RCV_CYC, 2, cycles a thread stays blocked after a rollback (>=1).
- Derived: CNT_W = $clog2(DP_NUM+1); THREAD_W = max(1, $clog2(THREAD_NUM)).

Ports:
- clk_i, in, 1, clock; all state updates on the rising edge.
- rst_i, in, 1, asynchronous active-high reset.
- dp_req_i, in, THREAD_NUM x CNT_W, instructions ready to dispatch per thread (0..DP_NUM).
- rob_avail_i, in, THREAD_NUM x CNT_W, free ROB entries per thread, saturated to DP_NUM.
- rs_avail_i, in, CNT_W, free RS entries, saturated to DP_NUM.
- fl_avail_i, in, CNT_W, free physical registers, saturated to DP_NUM.
- rollback_i, in, THREAD_NUM, per-thread branch-mispredict rollback request.
- dp_gnt_o, out, THREAD_NUM x CNT_W, granted instruction count per thread.
- port_valid_o, out, DP_NUM, port k carries an instruction this cycle.
- port_thread_o, out, DP_NUM x THREAD_W, owning thread of port k.
- mt_rollback_o, out, THREAD_NUM, rollback strobe to the map table.
- busy_o, out, THREAD_NUM, thread is in RECOVER.

Behaviour:
- State: rr_ptr (THREAD_W bits); per thread, an FSM {RUN, RECOVER} plus a recovery counter rcv_cnt.
- Reset (asynchronous, while rst_i=1): rr_ptr=0, all threads RUN, rcv_cnt=0. All outputs read 0 while rst_i is high; outputs are gated by rst_i.
- Outputs are combinational from inputs and current state; zero-latency grant within the same cycle.
- Eligibility of thread t requires all of the following:
  - state[t]==RUN
  - !rollback_i[t]
  - dp_req_i[t]>0
  - rob_avail_i[t]>0, rs_avail_i>0 and fl_avail_i>0
- Winner selection:
  - Scan t = rr_ptr, rr_ptr+1, ... mod THREAD_NUM; the first eligible thread wins.
  - Only one thread is granted per cycle.
- Grant count n = min(dp_req_i[w], rob_avail_i[w], rs_avail_i, fl_avail_i, DP_NUM).
  - dp_gnt_o[w]=n; every other thread's dp_gnt_o is 0.
- Port packing:
  - port_valid_o[k]=1 for k<n, contiguous from port 0.
  - port_thread_o[k]=w for k<n, 0 otherwise.
- rr_ptr update:
  - If a grant occurs, rr_ptr <= (w+1) mod THREAD_NUM.
  - Otherwise rr_ptr holds.
- Rollback:
  - mt_rollback_o[t] = rollback_i[t] && !rst_i, same cycle.
  - Next edge: state[t] <= RECOVER, rcv_cnt[t] <= RCV_CYC-1.
- RECOVER:
  - busy_o[t]=1 and the thread is ineligible.
  - Each cycle, if rcv_cnt==0 then state <= RUN, else decrement.
  - Total blocked cycles after the rollback cycle is exactly RCV_CYC.
- Rollback arriving while the thread is already in RECOVER restarts rcv_cnt at RCV_CYC-1 and pulses mt_rollback_o again.
- Simultaneous rollback and request for the same thread: the rollback wins and the thread gets zero grant that cycle. Other threads are still arbitrated normally and may receive ports.
- Simultaneous rollbacks on several threads are all honoured independently.
- If any resource input is 0, no grant occurs and rr_ptr holds.
- rst_i asserted mid-recovery returns every thread to RUN immediately.

Decomposition:
- Shared package: THREAD_NUM/DP_NUM defaults, the CNT_W/THREAD_W derivation helpers, and a thread FSM enum typedef (RUN, RECOVER).
- Natural sub-module mt_thread_rcv: one per thread (generate loop), holding the FSM and rcv_cnt, with inputs rollback and reset and output busy.
- Arbitration and min/packing logic stay in the top module.

Test Plan:
- Reset and idle: rst_i=1 with dp_req={2,2} → all outputs 0. Deassert with all inputs 0 → dp_gnt={0,0}, port_valid=00.
- Round-robin: dp_req={2,2}, all avail=2 for 4 cycles → winners T0,T1,T0,T1; port_valid=11; port_thread alternates 0,0 / 1,1.
- Resource limiting: dp_req[0]=2, rob_avail[0]=2, rs_avail=2, fl_avail=1 → dp_gnt[0]=1, port_valid=01. Then with fl_avail=0 → no grant and rr_ptr unchanged.
- Rollback, RCV_CYC=2, at cycle N on T0 with both threads requesting:
  - Cycle N: mt_rollback_o=01, T1 granted.
  - Cycles N+1..N+2: busy_o[0]=1, only T1 granted.
  - Cycle N+3: T0 eligible again.
- Rollback during RECOVER: second rollback_i[0] at N+2 → mt_rollback_o[0] pulses; busy_o[0] holds through N+4 and T0 is granted again at N+5.
- Asynchronous reset mid-recovery: assert rst_i between edges at N+1 → busy_o=00 immediately. After release, T0 is granted when requesting.
